// File: rtl/config_stream_pkg.sv
// Shared types and helpers for the configuration word stream transmitter.
// Holds the session FSM states and the sync/desync word builders.
package config_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    HEADER,
    DATA,
    DESYNC
  } cst_state_e;

  localparam logic [31:0] SYNC_WORD           = 32'hFAB0_FAB1;
  localparam int unsigned DESYNC_FLAG_DEFAULT = 20;

  // Desync word: all zero except the receiver's desync flag bit.
  function automatic logic [31:0] desync_word(input int unsigned flag);
    return 32'd1 << flag;
  endfunction

  // Headers must never carry the desync flag, or the receiver would drop out.
  function automatic logic [31:0] mask_header(input logic [31:0] addr,
                                              input int unsigned flag);
    return addr & ~desync_word(flag);
  endfunction

endpackage

// File: rtl/config_stream_tx.sv
// Transmitter for the fabric configuration stream: sync, framed data, desync.
// Word outputs are registered; handshake readies are combinational.
module config_stream_tx
  import config_stream_pkg::*;
#(
  parameter int unsigned  NumberOfRows    = 15,
  parameter int unsigned  FrameBitsPerRow = 32,
  parameter int unsigned  desync_flag     = DESYNC_FLAG_DEFAULT,
  parameter logic [31:0]  SyncWord        = SYNC_WORD,
  parameter int unsigned  CountWidth      = 16
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       Abort,
  input  logic                       FrameValid,
  input  logic [FrameBitsPerRow-1:0] FrameAddress,
  input  logic                       FrameLast,
  output logic                       FrameReady,
  input  logic                       DataValid,
  input  logic [FrameBitsPerRow-1:0] DataIn,
  output logic                       DataReady,
  output logic [FrameBitsPerRow-1:0] WriteData,
  output logic                       WriteStrobe,
  output logic                       Busy,
  output logic                       Done,
  output logic [CountWidth-1:0]      FrameCount
);

  localparam int RW = $clog2(NumberOfRows + 1);

  cst_state_e                 state_q, state_d;
  logic [RW-1:0]              row_q, row_d;
  logic [CountWidth-1:0]      fcnt_q, fcnt_d;
  logic                       pend_q, pend_d;
  logic                       last_q, last_d;
  logic [FrameBitsPerRow-1:0] wdata_q, wdata_d;
  logic                       wstrb_q, wstrb_d;
  logic                       done_q, done_d;

  assign FrameReady  = (state_q == HEADER) & FrameValid & ~pend_q;
  assign DataReady   = (state_q == DATA) & DataValid;
  assign WriteData   = wdata_q;
  assign WriteStrobe = wstrb_q;
  assign Busy        = (state_q != IDLE);
  assign Done        = done_q;
  assign FrameCount  = fcnt_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      fcnt_q  <= '0;
      pend_q  <= 1'b0;
      last_q  <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    fcnt_d  = fcnt_q;
    pend_d  = pend_q;
    last_d  = last_q;
    wdata_d = wdata_q;
    wstrb_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          fcnt_d  = '0;
          state_d = SYNC;
        end
      end
      SYNC: begin
        wdata_d = SyncWord;
        wstrb_d = 1'b1;
        // An abort here must survive until HEADER can act on it.
        if (Abort) pend_d = 1'b1;
        state_d = HEADER;
      end
      HEADER: begin
        if (Abort || pend_q) begin
          state_d = DESYNC;
        end else if (FrameValid) begin
          wdata_d = mask_header(FrameAddress, desync_flag);
          wstrb_d = 1'b1;
          last_d  = FrameLast;
          row_d   = RW'(NumberOfRows);
          state_d = DATA;
        end
      end
      DATA: begin
        // Frames always run to completion; abort is deferred to the next header slot.
        if (Abort) pend_d = 1'b1;
        if (DataValid) begin
          wdata_d = DataIn;
          wstrb_d = 1'b1;
          row_d   = row_q - RW'(1);
          if (row_q == RW'(1)) begin
            fcnt_d  = fcnt_q + CountWidth'(1);
            state_d = (last_q || pend_q) ? DESYNC : HEADER;
          end
        end
      end
      DESYNC: begin
        wdata_d = desync_word(desync_flag);
        wstrb_d = 1'b1;
        done_d  = 1'b1;
        pend_d  = 1'b0;
        last_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_config_stream_tx.sv
// Scoreboard bench for config_stream_tx: expected words are queued as stimulus
// is planned and popped whenever the transmitter strobes a word.
module tb_config_stream_tx;

  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'h0010_0000;

  logic        CLK = 1'b0;
  logic        Reset, Start, Abort, FrameValid, FrameLast, DataValid;
  logic [31:0] FrameAddress, DataIn;
  logic        FrameReady, DataReady, WriteStrobe, Busy, Done;
  logic [31:0] WriteData;
  logic [15:0] FrameCount;

  config_stream_tx dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Abort(Abort),
    .FrameValid(FrameValid), .FrameAddress(FrameAddress), .FrameLast(FrameLast),
    .FrameReady(FrameReady), .DataValid(DataValid), .DataIn(DataIn),
    .DataReady(DataReady), .WriteData(WriteData), .WriteStrobe(WriteStrobe),
    .Busy(Busy), .Done(Done), .FrameCount(FrameCount)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          strb_cnt = 0;
  int          done_cnt = 0;
  int          fr_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Monitor: every strobed word is checked against the scoreboard head.
  always @(negedge CLK) begin
    if (!Reset) begin
      if (FrameReady && FrameValid) fr_cnt++;
      if (Done) begin
        done_cnt++;
        chk("done_with_desync", {WriteStrobe, WriteData[30:0]}, {1'b1, DESYNC[30:0]});
      end
      if (WriteStrobe) begin
        strb_cnt++;
        if (exp_q.size() == 0) chk("extra_strobe", WriteData, 32'hxxxx_xxxx);
        else chk("word", WriteData, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic start_session();
    exp_q.push_back(SYNC);
    Start = 1'b1; tick(); Start = 1'b0;
  endtask

  task automatic send_desc(input logic [31:0] addr, input logic last, input logic [31:0] exp_hdr);
    bit ok = 0;
    exp_q.push_back(exp_hdr);
    FrameValid = 1'b1; FrameAddress = addr; FrameLast = last;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge CLK);
      if (FrameReady) ok = 1;
      else begin @(posedge CLK); #1; end
    end
    if (!ok) chk("desc_timeout", 32'd0, 32'd1);
    tick();
    FrameValid = 1'b0;
  endtask

  task automatic send_data(input int n, input logic [31:0] base, input bit gap);
    for (int i = 0; i < n; i++) begin
      bit ok = 0;
      if (gap) begin DataValid = 1'b0; tick(); end
      exp_q.push_back(base + 32'(i));
      DataValid = 1'b1; DataIn = base + 32'(i);
      for (int t = 0; t < 100 && !ok; t++) begin
        @(negedge CLK);
        if (DataReady) ok = 1;
        else begin @(posedge CLK); #1; end
      end
      if (!ok) chk("data_timeout", 32'd0, 32'd1);
      tick();
      DataValid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge CLK);
      if (!Busy && exp_q.size() == 0) ok = 1;
    end
    chk({tag, "_idle"}, 32'(ok), 32'd1);
    tick();
  endtask

  task automatic clear_counts();
    strb_cnt = 0; done_cnt = 0; fr_cnt = 0;
  endtask

  initial begin
    Reset = 1'b1; Start = 0; Abort = 0; FrameValid = 0; FrameLast = 0;
    DataValid = 0; FrameAddress = '0; DataIn = '0;
    #12;
    chk("rst_wdata", WriteData, 32'd0);
    chk("rst_strobe", 32'(WriteStrobe), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_fcnt", 32'(FrameCount), 32'd0);
    chk("rst_ready", {30'd0, FrameReady, DataReady}, 32'd0);
    Reset = 1'b0;
    tick();

    // 1: single frame, last
    clear_counts();
    start_session();
    send_desc(32'h0000_0003, 1'b1, 32'h0000_0003);
    send_data(15, 32'd1, 1'b0);
    exp_q.push_back(DESYNC);
    wait_idle("t1");
    chk("t1_fcnt", 32'(FrameCount), 32'd1);
    chk("t1_done", 32'(done_cnt), 32'd1);
    chk("t1_strobes", 32'(strb_cnt), 32'd18);

    // 2: two frames, DataValid gapped
    clear_counts();
    start_session();
    send_desc(32'h0000_0010, 1'b0, 32'h0000_0010);
    send_data(15, 32'h100, 1'b1);
    send_desc(32'h0000_0011, 1'b1, 32'h0000_0011);
    send_data(15, 32'h200, 1'b1);
    exp_q.push_back(DESYNC);
    wait_idle("t2");
    chk("t2_fcnt", 32'(FrameCount), 32'd2);
    chk("t2_strobes_no_sync", 32'(strb_cnt - 1), 32'd33);

    // 3: header masking
    clear_counts();
    start_session();
    send_desc(32'hFFFF_FFFF, 1'b1, 32'hFFEF_FFFF);
    send_data(15, 32'hA000_0000, 1'b0);
    exp_q.push_back(DESYNC);
    wait_idle("t3");
    chk("t3_fcnt", 32'(FrameCount), 32'd1);

    // 4: abort mid-frame; frame completes, next descriptor refused
    clear_counts();
    start_session();
    send_desc(32'h0000_0020, 1'b0, 32'h0000_0020);
    send_data(5, 32'd1, 1'b0);
    Abort = 1'b1; tick(); Abort = 1'b0;
    send_data(10, 32'd6, 1'b0);
    exp_q.push_back(DESYNC);
    FrameValid = 1'b1; FrameAddress = 32'h0000_0021; FrameLast = 1'b1;
    wait_idle("t4");
    FrameValid = 1'b0;
    chk("t4_fcnt", 32'(FrameCount), 32'd1);
    chk("t4_frame_ready", 32'(fr_cnt), 32'd1);
    chk("t4_done", 32'(done_cnt), 32'd1);

    // 5: abort while idling in HEADER
    clear_counts();
    start_session();
    tick(); tick(); tick();
    exp_q.push_back(DESYNC);
    Abort = 1'b1; tick(); Abort = 1'b0;
    wait_idle("t5");
    chk("t5_done", 32'(done_cnt), 32'd1);
    chk("t5_fcnt", 32'(FrameCount), 32'd0);

    // 6: async reset during the second frame's data
    clear_counts();
    start_session();
    send_desc(32'h0000_0030, 1'b0, 32'h0000_0030);
    send_data(15, 32'h300, 1'b0);
    send_desc(32'h0000_0031, 1'b1, 32'h0000_0031);
    send_data(4, 32'h400, 1'b0);
    DataValid = 1'b1; DataIn = 32'h404;
    @(negedge CLK);
    chk("t6_pre_fcnt", 32'(FrameCount), 32'd1);
    #1 Reset = 1'b1;
    #1;
    chk("t6_strobe", 32'(WriteStrobe), 32'd0);
    chk("t6_busy", 32'(Busy), 32'd0);
    chk("t6_fcnt", 32'(FrameCount), 32'd0);
    DataValid = 1'b0;
    exp_q.delete();
    tick();
    Reset = 1'b0;
    tick();
    clear_counts();
    start_session();
    send_desc(32'h0000_0040, 1'b1, 32'h0000_0040);
    send_data(15, 32'h500, 1'b0);
    exp_q.push_back(DESYNC);
    wait_idle("t6");
    chk("t6_post_fcnt", 32'(FrameCount), 32'd1);
    chk("t6_post_strobes", 32'(strb_cnt), 32'd18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
